// File: rtl/blood_sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : blood_sprite_animator
// Brief    : Plays a keyed blood-splatter animation from a 64x64 frame ROM bank.
// Revision : 1.0 - initial release
// ============================================================================
module blood_sprite_animator #(
    parameter int          SPRITE_DIM  = 64,
    parameter int          FRAME_COUNT = 4,
    parameter int          FRAME_TICKS = 6,
    parameter logic [11:0] KEY_COLOR   = 12'h000,
    localparam int         ADDR_W      = $clog2(SPRITE_DIM),
    localparam int         SEL_W       = (FRAME_COUNT > 1) ? $clog2(FRAME_COUNT) : 1,
    localparam int         TICK_W      = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              video_on,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              frame_tick,
    input  logic              hit,
    input  logic [9:0]        hit_x,
    input  logic [9:0]        hit_y,
    output logic [ADDR_W-1:0] rom_row,
    output logic [ADDR_W-1:0] rom_col,
    output logic [SEL_W-1:0]  rom_frame_sel,
    input  logic [11:0]       rom_color,
    output logic              busy,
    output logic              pix_valid,
    output logic [11:0]       pix_color
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    localparam logic [9:0]        c_half_dim   = 10'(SPRITE_DIM / 2);
    localparam logic [10:0]       c_dim        = 11'(SPRITE_DIM);
    localparam logic [TICK_W-1:0] c_last_tick  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [SEL_W-1:0]  c_last_frame = SEL_W'(FRAME_COUNT - 1);

    state_t             r_state, w_state_next;
    logic [9:0]         r_pos_x, r_pos_y, w_pos_x_next, w_pos_y_next;
    logic [TICK_W-1:0]  r_tick_cnt, w_tick_next;
    logic [SEL_W-1:0]   r_frame_idx, w_frame_next;
    logic               r_in_box_d;
    logic [10:0]        w_dx, w_dy;
    logic               w_in_box;
    logic               w_pix_valid_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pos_x     <= '0;
            r_pos_y     <= '0;
            r_tick_cnt  <= '0;
            r_frame_idx <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pos_x     <= w_pos_x_next;
            r_pos_y     <= w_pos_y_next;
            r_tick_cnt  <= w_tick_next;
            r_frame_idx <= w_frame_next;
        end
    end

    // A hit always wins, including over the tick that would end the effect.
    always_comb begin
        w_state_next = r_state;
        w_pos_x_next = r_pos_x;
        w_pos_y_next = r_pos_y;
        w_tick_next  = r_tick_cnt;
        w_frame_next = r_frame_idx;
        if (hit) begin
            w_state_next = S_ARMED;
            w_pos_x_next = (hit_x >= c_half_dim) ? (hit_x - c_half_dim) : '0;
            w_pos_y_next = (hit_y >= c_half_dim) ? (hit_y - c_half_dim) : '0;
        end else if (frame_tick) begin
            case (r_state)
                S_ARMED: begin
                    w_state_next = S_PLAY;
                    w_tick_next  = '0;
                    w_frame_next = '0;
                end
                S_PLAY: begin
                    if (r_tick_cnt == c_last_tick) begin
                        w_tick_next = '0;
                        if (r_frame_idx == c_last_frame) begin
                            w_state_next = S_IDLE;
                            w_frame_next = '0;
                        end else begin
                            w_frame_next = r_frame_idx + 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + 1'b1;
                    end
                end
                S_IDLE:  ;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // 11-bit offsets so a sprite near the right/bottom edge clips instead of wrapping.
    always_comb begin
        w_dx     = {1'b0, x} - {1'b0, r_pos_x};
        w_dy     = {1'b0, y} - {1'b0, r_pos_y};
        w_in_box = video_on && (r_state == S_PLAY) &&
                   (x >= r_pos_x) && (y >= r_pos_y) &&
                   (w_dx < c_dim) && (w_dy < c_dim);
        w_pix_valid_next = r_in_box_d && (rom_color != KEY_COLOR);
    end

    assign rom_col       = w_dx[ADDR_W-1:0];
    assign rom_row       = w_dy[ADDR_W-1:0];
    assign rom_frame_sel = r_frame_idx;
    assign busy          = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_box_d <= 1'b0;
            pix_valid  <= 1'b0;
            pix_color  <= '0;
        end else begin
            r_in_box_d <= w_in_box;
            pix_valid  <= w_pix_valid_next;
            pix_color  <= w_pix_valid_next ? rom_color : 12'h000;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_blood_sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : tb_blood_sprite_animator
// Brief    : Directed bench for blood_sprite_animator with a per-cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blood_sprite_animator;

    localparam int DIM    = 64;
    localparam int NFRM   = 4;
    localparam int NTICK  = 6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0, y = '0;
    logic        frame_tick = 1'b0;
    logic        hit = 1'b0;
    logic [9:0]  hit_x = '0, hit_y = '0;
    logic [11:0] rom_color = '0;
    logic [11:0] pend = '0;
    logic [5:0]  rom_row, rom_col;
    logic [1:0]  rom_frame_sel;
    logic        busy, pix_valid;
    logic [11:0] pix_color;

    int checks = 0;
    int errors = 0;

    blood_sprite_animator dut (
        .clk(clk), .reset_n(reset_n), .video_on(video_on), .x(x), .y(y),
        .frame_tick(frame_tick), .hit(hit), .hit_x(hit_x), .hit_y(hit_y),
        .rom_row(rom_row), .rom_col(rom_col), .rom_frame_sel(rom_frame_sel),
        .rom_color(rom_color), .busy(busy), .pix_valid(pix_valid), .pix_color(pix_color)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 idle, 1 armed, 2 playing; frame derived from ticks seen while playing.
    int          m_state = 0;
    int          m_px = 0, m_py = 0, m_play_ticks = 0;
    bit          m_stage1 = 0;
    bit          e_valid = 0;
    logic [11:0] e_color = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_state = 0; m_px = 0; m_py = 0; m_play_ticks = 0;
            m_stage1 = 0; e_valid = 0; e_color = '0;
        end else begin
            e_valid  = m_stage1 && (rom_color != 12'h000);
            e_color  = e_valid ? rom_color : 12'h000;
            m_stage1 = video_on && (m_state == 2) &&
                       (int'(x) >= m_px) && (int'(x) < m_px + DIM) &&
                       (int'(y) >= m_py) && (int'(y) < m_py + DIM);
            if (hit) begin
                m_px = (int'(hit_x) >= DIM/2) ? int'(hit_x) - DIM/2 : 0;
                m_py = (int'(hit_y) >= DIM/2) ? int'(hit_y) - DIM/2 : 0;
                m_state = 1;
            end else if (frame_tick) begin
                if (m_state == 1) begin
                    m_state = 2;
                    m_play_ticks = 0;
                end else if (m_state == 2) begin
                    m_play_ticks++;
                    if (m_play_ticks == NTICK * NFRM) m_state = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_state != 0));
        chk("pix_valid", int'(pix_valid), int'(e_valid));
        chk("pix_color", int'(pix_color), int'(e_color));
        chk("rom_col", int'(rom_col), (int'(x) - m_px) & (DIM - 1));
        chk("rom_row", int'(rom_row), (int'(y) - m_py) & (DIM - 1));
        if (m_state == 2) chk("frame_sel", int'(rom_frame_sel), m_play_ticks / NTICK);
    end

    // rom_color for a pixel arrives on the cycle after its address.
    task automatic drive(input logic [9:0] xx, input logic [9:0] yy,
                         input logic von, input logic [11:0] col);
        x = xx; y = yy; video_on = von;
        rom_color = pend;
        pend = col;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic px(input logic [9:0] xx, input logic [9:0] yy,
                      input logic von, input logic [11:0] col);
        drive(xx, yy, von, col);
        cyc();
    endtask

    task automatic idle();
        drive(x, y, 1'b0, 12'h000);
        cyc();
    endtask

    task automatic pulse_hit(input logic [9:0] hx, input logic [9:0] hy);
        hit = 1'b1; hit_x = hx; hit_y = hy;
        idle();
        hit = 1'b0;
    endtask

    task automatic ftick();
        frame_tick = 1'b1;
        idle();
        frame_tick = 1'b0;
    endtask

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        chk("reset_busy", int'(busy), 0);
        chk("reset_sel", int'(rom_frame_sel), 0);

        // Basic play at (320,240): box 288..351 x 208..271
        pulse_hit(10'd320, 10'd240);
        chk("armed_busy", int'(busy), 1);
        px(10'd320, 10'd240, 1'b1, 12'hABC); idle();
        chk("armed_no_pix", int'(pix_valid), 0);
        ftick();
        chk("play_sel0", int'(rom_frame_sel), 0);
        px(10'd288, 10'd208, 1'b1, 12'h111);
        px(10'd287, 10'd208, 1'b1, 12'h222);
        px(10'd351, 10'd271, 1'b1, 12'h333);
        px(10'd352, 10'd271, 1'b1, 12'h444);
        px(10'd300, 10'd207, 1'b1, 12'h555);
        idle(); idle();

        drive(10'd300, 10'd210, 1'b1, 12'hE00);
        #1;
        chk("addr_col", int'(rom_col), 12);
        chk("addr_row", int'(rom_row), 2);
        cyc(); idle();
        chk("lat_valid", int'(pix_valid), 1);
        chk("lat_color", int'(pix_color), 12'hE00);
        px(10'd300, 10'd210, 1'b1, 12'h000); idle();
        chk("key_valid", int'(pix_valid), 0);

        for (int k = 1; k <= 24; k++) begin
            ftick();
            px(10'(300 + k), 10'd220, 1'b1, 12'(k));
            idle();
            if (k < 24) chk("adv_sel", int'(rom_frame_sel), k / 6);
            else        chk("end_busy", int'(busy), 0);
        end

        // Clamp at the top-left corner
        pulse_hit(10'd10, 10'd5);
        ftick();
        drive(10'd0, 10'd0, 1'b1, 12'h123);
        #1;
        chk("clamp_col0", int'(rom_col), 0);
        chk("clamp_row0", int'(rom_row), 0);
        cyc();
        drive(10'd5, 10'd3, 1'b1, 12'h456);
        #1;
        chk("clamp_col5", int'(rom_col), 5);
        chk("clamp_row3", int'(rom_row), 3);
        cyc(); idle();
        chk("clamp_vis", int'(pix_valid), 1);

        // Clip at the bottom-right corner: box 598..639 x 438..479
        pulse_hit(10'd630, 10'd470);
        ftick();
        px(10'd0, 10'd440, 1'b1, 12'h0AA); idle();
        chk("clip_nowrap", int'(pix_valid), 0);
        px(10'd639, 10'd470, 1'b1, 12'h0BB); idle();
        chk("clip_edge", int'(pix_valid), 1);

        // Retrigger in frame 1
        repeat (6) ftick();
        chk("retrig_sel1", int'(rom_frame_sel), 1);
        pulse_hit(10'd100, 10'd100);
        chk("retrig_busy", int'(busy), 1);
        px(10'd68, 10'd68, 1'b1, 12'hC0C); idle();
        chk("retrig_armed", int'(pix_valid), 0);
        ftick();
        chk("retrig_sel0", int'(rom_frame_sel), 0);
        drive(10'd68, 10'd68, 1'b1, 12'hC0C);
        #1;
        chk("retrig_col", int'(rom_col), 0);
        chk("retrig_row", int'(rom_row), 0);
        cyc(); idle();
        chk("retrig_vis", int'(pix_valid), 1);

        // Hit coincident with the final tick
        repeat (23) ftick();
        hit = 1'b1; hit_x = 10'd200; hit_y = 10'd200; frame_tick = 1'b1;
        idle();
        hit = 1'b0; frame_tick = 1'b0;
        chk("coll_busy", int'(busy), 1);
        px(10'd200, 10'd200, 1'b1, 12'h0F0); idle();
        chk("coll_armed", int'(pix_valid), 0);
        ftick();
        px(10'd200, 10'd200, 1'b1, 12'h0F0); idle();
        chk("coll_vis", int'(pix_valid), 1);
        chk("coll_color", int'(pix_color), 12'h0F0);

        // Blanking inside the box
        px(10'd200, 10'd200, 1'b0, 12'hE00); idle();
        chk("blank", int'(pix_valid), 0);

        // Reset mid-play at frame 2
        repeat (12) ftick();
        chk("rst_sel2", int'(rom_frame_sel), 2);
        px(10'd200, 10'd200, 1'b1, 12'h777); idle();
        chk("rst_pre_vis", int'(pix_valid), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_pix", int'(pix_valid), 0);
        chk("rst_async_sel", int'(rom_frame_sel), 0);
        repeat (3) cyc();
        reset_n = 1'b1;
        cyc();
        ftick();
        px(10'd200, 10'd200, 1'b1, 12'h777); idle();
        chk("rst_post_pix", int'(pix_valid), 0);
        chk("rst_post_busy", int'(busy), 0);
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/blood_sprite_animator.md
Name: blood_sprite_animator

Overview:
- Drives a bank of 64x64, 12-bit blood-splatter frame ROMs.
- On a hit event, it latches a screen position and plays FRAME_COUNT frames at a fixed rate.
- For each VGA pixel it generates the row/col address, consumes the returned colour one cycle later, and outputs a keyed pixel for the compositor.
- It sits between the VGA sync/pixel counter and the blood ROM bank, upstream of the display mux.

Parameters:
- SPRITE_DIM, 64: sprite width and height in pixels; ROM row/col are log2(SPRITE_DIM)=6 bits.
- FRAME_COUNT, 4: number of animation frames in the ROM bank.
- FRAME_TICKS, 6: video frames each animation frame is held.
- KEY_COLOR, 12'h000: transparent colour; never emitted as a valid pixel.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- video_on  in  1  current x/y is in the visible area
- x  in  10  current pixel column (0..639)
- y  in  10  current pixel row (0..479)
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- hit  in  1  one-cycle pulse requesting an effect
- hit_x  in  10  hit centre column, sampled when hit=1
- hit_y  in  10  hit centre row, sampled when hit=1
- rom_row  out  6  ROM row address, combinational from x/y
- rom_col  out  6  ROM column address, combinational from x/y
- rom_frame_sel  out  2  selects the ROM in the bank (clog2(FRAME_COUNT))
- rom_color  in  12  ROM data, valid the cycle after the address (ROM registers the address internally)
- busy  out  1  effect armed or playing
- pix_valid  out  1  registered; the sprite covers this pixel and it is opaque
- pix_color  out  12  registered pixel colour

Behaviour:
- Reset (asynchronous, reset_n=0) returns the block to IDLE:
  - busy=0, pix_valid=0, pix_color=0, rom_frame_sel=0.
  - Position registers, tick counter and pipeline registers all cleared.
  - Reset applied mid-PLAY aborts the effect immediately.
- Position latch on hit=1:
  - pos_x = hit_x-32 and pos_y = hit_y-32, each clamped at 0 (no underflow wrap).
  - Stored as 10 bits.
- FSM states:
  - IDLE: hit -> ARMED.
  - ARMED: waits for frame_tick, so the effect never starts mid-frame. On frame_tick -> PLAY with frame_idx=0 and tick_cnt=0.
  - PLAY: on frame_tick, tick_cnt increments. At tick_cnt==FRAME_TICKS-1, tick_cnt clears and frame_idx increments. If frame_idx==FRAME_COUNT-1 at that point, go to IDLE.
  - Retrigger: hit in ARMED or PLAY re-latches the position and goes to ARMED (restart from frame 0).
  - hit and the final frame_tick in the same cycle: the hit wins, go to ARMED.
- busy=1 in ARMED and PLAY.
- rom_frame_sel = frame_idx, and changes only on a frame_tick edge, so there is no tearing.
- Addressing:
  - dx = x - pos_x and dy = y - pos_y, computed in 11 bits.
  - in_box = video_on & state==PLAY & x>=pos_x & y>=pos_y & dx<SPRITE_DIM & dy<SPRITE_DIM.
  - rom_col = dx[5:0] and rom_row = dy[5:0], driven regardless of in_box.
  - Compare pos_x+SPRITE_DIM in 11 bits; near the right or bottom edge the sprite clips and never wraps to column 0.
- Pipeline, total latency 2 cycles from x/y to pix_*:
  - Cycle N: x/y presented and address driven; in_box registered into in_box_d at edge N+1.
  - Cycle N+1: rom_color is valid.
  - Edge N+2: pix_valid <= in_box_d & (rom_color != KEY_COLOR); pix_color <= pix_valid-next ? rom_color : 0.
  - The compositor delays its own background by 2 cycles.
- A state change mid-line affects only pixels whose address is presented after the change; in-flight pixels complete unchanged.
- frame_tick outside PLAY/ARMED is ignored.

Test Plan:
- Reset mid-PLAY:
  - Stimulus: reset_n=0 for 3 cycles at frame_idx=2.
  - Response: busy=0, pix_valid=0, rom_frame_sel=0 asynchronously; nothing displayed after release until a new hit.
- Basic play:
  - Stimulus: hit at (320,240).
  - Response: busy=1. No pix_valid before the first frame_tick. Sprite box x 288..351, y 208..271. rom_frame_sel advances 0->1->2->3 every 6 frame_ticks. busy=0 after the 24th frame_tick.
- Addressing and latency:
  - Stimulus: in PLAY with pos=(288,208), present x=300, y=210.
  - Response: rom_col=12 and rom_row=2 the same cycle. Drive rom_color=12'hE00 next cycle -> pix_valid=1, pix_color=12'hE00 two cycles after x/y. rom_color=12'h000 -> pix_valid=0.
- Clamping and clipping:
  - Stimulus: hit at (10,5).
  - Response: pos=(0,0); x=0,y=0 gives rom_row=0, rom_col=0.
  - Stimulus: hit at (630,470).
  - Response: box x 598..639; x=0 is never in_box (no wrap).
- Retrigger and collision:
  - Stimulus: hit at (100,100) in PLAY frame 1.
  - Response: ARMED, busy stays 1, new pos=(68,68), frame 0 on the next frame_tick.
  - Stimulus: hit coincident with the last frame_tick.
  - Response: ARMED, not IDLE.
- Blanking:
  - Stimulus: video_on=0 with x/y inside the box.
  - Response: pix_valid=0 two cycles later.
